// File: rtl/vga_text_pkg.sv
// Shared definitions for the text console writer.
// Holds the default screen geometry, the blank fill code, the control codes
// the writer interprets, the writer FSM state type and the cursor operation
// type used between the writer and its cursor sub-block.
package vga_text_pkg;

    localparam int TEXT_COLS  = 80;                     // 640 px / 8 px glyphs
    localparam int TEXT_ROWS  = 40;                     // 480 px / 12 px glyphs
    localparam int TEXT_CELLS = TEXT_COLS * TEXT_ROWS;

    localparam logic [7:0] TEXT_FILL = 8'h20;

    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_FF = 8'h0C;
    localparam logic [7:0] CODE_CR = 8'h0D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_CLR_LINE,
        ST_CLR_SCREEN
    } state_t;

    typedef enum logic [2:0] {
        CUR_HOLD,
        CUR_ADVANCE,
        CUR_NEWLINE,
        CUR_RETURN,
        CUR_BACK,
        CUR_HOME
    } cursor_op_t;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= 8'h20) && (code <= 8'h7E);
    endfunction

endpackage

// File: rtl/text_cursor.sv
// Column/row cursor for the text console.
// Ports:
//   clock25, reset_n : clock and asynchronous active-low reset
//   op               : one cursor operation per cycle (hold, advance,
//                      newline, carriage return, back, home)
//   col, row         : current cursor position
//   at_last_col      : cursor sits in the last column, so an advance wraps
module text_cursor
    import vga_text_pkg::*;
#(
    parameter int COLS = TEXT_COLS,
    parameter int ROWS = TEXT_ROWS
) (
    input  logic       clock25,
    input  logic       reset_n,
    input  cursor_op_t op,
    output logic [6:0] col,
    output logic [5:0] row,
    output logic       at_last_col
);

    localparam logic [6:0] LAST_COL = 7'(COLS - 1);
    localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

    logic [5:0] next_row;

    // The bottom row wraps to the top; the writer then clears that line.
    assign next_row    = (row == LAST_ROW) ? 6'd0 : row + 6'd1;
    assign at_last_col = (col == LAST_COL);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else begin
            case (op)
                CUR_ADVANCE: begin
                    if (at_last_col) begin
                        col <= '0;
                        row <= next_row;
                    end else begin
                        col <= col + 7'd1;
                    end
                end
                CUR_NEWLINE: begin
                    col <= '0;
                    row <= next_row;
                end
                CUR_RETURN: col <= '0;
                CUR_BACK: begin
                    if (col != 7'd0) col <= col - 7'd1;
                end
                CUR_HOME: begin
                    col <= '0;
                    row <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// Character-stream writer for a text-mode screen memory.
// Accepts one character code at a time, interprets printable codes and the
// LF/CR/BS/FF controls, and emits one cell write per cycle to an external
// screen memory (row*COLS + col addressing). Line and screen clears fill
// with FILL_CHAR.
// Ports:
//   clock25, reset_n      : clock and asynchronous active-low reset
//   char_valid, char_data : producer side, code taken when char_ready is high
//   char_ready            : writer is idle and out of reset
//   wr_en/wr_addr/wr_data : screen-memory write port
//   cursor_col/cursor_row : current cursor position
//   busy                  : writer is in any state other than IDLE
module text_console_writer
    import vga_text_pkg::*;
#(
    parameter int         COLS      = TEXT_COLS,
    parameter int         ROWS      = TEXT_ROWS,
    parameter logic [7:0] FILL_CHAR = TEXT_FILL
) (
    input  logic        clock25,
    input  logic        reset_n,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    output logic        wr_en,
    output logic [11:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic [6:0]  cursor_col,
    output logic [5:0]  cursor_row,
    output logic        busy
);

    localparam logic [11:0] LAST_COL  = 12'(COLS - 1);
    localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);

    state_t      state_q, state_d;
    logic [7:0]  code_q, code_d;
    logic        bs_q, bs_d;        // pending write is a backspace erase
    logic [11:0] cnt_q, cnt_d;      // clear-sweep offset
    cursor_op_t  cur_op;
    logic        at_last_col;
    logic        accept;
    logic [11:0] row_base;

    assign char_ready = (state_q == ST_IDLE) && reset_n;
    assign busy       = (state_q != ST_IDLE);
    assign accept     = char_valid && char_ready;
    assign row_base   = 12'(cursor_row) * 12'(COLS);

    text_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clock25     (clock25),
        .reset_n     (reset_n),
        .op          (cur_op),
        .col         (cursor_col),
        .row         (cursor_row),
        .at_last_col (at_last_col)
    );

    always_ff @(posedge clock25 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            bs_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            bs_q    <= bs_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        bs_d    = bs_q;
        cnt_d   = cnt_q;
        cur_op  = CUR_HOLD;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    cnt_d = '0;
                    bs_d  = 1'b0;
                    if (is_printable(char_data)) begin
                        code_d  = char_data;
                        state_d = ST_WRITE;
                    end else begin
                        case (char_data)
                            CODE_LF: begin
                                cur_op  = CUR_NEWLINE;
                                state_d = ST_CLR_LINE;
                            end
                            CODE_CR: cur_op = CUR_RETURN;
                            CODE_BS: begin
                                // The cursor steps back when WRITE finishes;
                                // the erase address is col-1 meanwhile.
                                if (cursor_col != 7'd0) begin
                                    bs_d    = 1'b1;
                                    code_d  = FILL_CHAR;
                                    state_d = ST_WRITE;
                                end
                            end
                            CODE_FF: begin
                                cur_op  = CUR_HOME;
                                state_d = ST_CLR_SCREEN;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            ST_WRITE: begin
                wr_en   = 1'b1;
                wr_data = code_q;
                wr_addr = row_base + (bs_q ? 12'(cursor_col) - 12'd1
                                           : 12'(cursor_col));
                cnt_d   = '0;
                if (bs_q) begin
                    cur_op  = CUR_BACK;
                    state_d = ST_IDLE;
                end else begin
                    // The cursor moves to the next row on this same edge, so
                    // CLR_LINE sweeps the freshly entered line.
                    cur_op  = CUR_ADVANCE;
                    state_d = at_last_col ? ST_CLR_LINE : ST_IDLE;
                end
            end

            ST_CLR_LINE: begin
                wr_en   = 1'b1;
                wr_data = FILL_CHAR;
                wr_addr = row_base + cnt_q;
                if (cnt_q == LAST_COL) state_d = ST_IDLE;
                else                   cnt_d   = cnt_q + 12'd1;
            end

            ST_CLR_SCREEN: begin
                wr_en   = 1'b1;
                wr_data = FILL_CHAR;
                wr_addr = cnt_q;
                if (cnt_q == LAST_CELL) state_d = ST_IDLE;
                else                    cnt_d   = cnt_q + 12'd1;
            end

            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer at default geometry
// (80 x 40). Writes seen on the memory port are logged at the falling edge
// and compared with hand-computed address/data sequences.
module tb_text_console_writer;

    logic        clock25;
    logic        reset_n;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [6:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t wlog[$];

    text_console_writer dut (
        .clock25    (clock25),
        .reset_n    (reset_n),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    initial begin
        clock25 = 1'b0;
        forever #5 clock25 = ~clock25;
    end

    always @(negedge clock25) begin
        if (wr_en === 1'b1) wlog.push_back({wr_addr, wr_data});
    end

    // Present one code for a single cycle; returns at the falling edge of
    // the cycle after acceptance.
    task automatic send(input logic [7:0] code);
        @(negedge clock25);
        char_valid = 1'b1;
        char_data  = code;
        @(negedge clock25);
        char_valid = 1'b0;
        char_data  = 8'hEE;
    endtask

    task automatic wait_idle(input int limit, output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < limit) begin
            cycles++;
            @(negedge clock25);
        end
        if (busy !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, cycles);
        end
    endtask

    task automatic check_cursor(input string name, input int col, input int row);
        vectors++;
        if (cursor_col !== 7'(col) || cursor_row !== 6'(row)) begin
            miscompares++;
            $display("FAIL %s: cursor=(%0d,%0d) required (%0d,%0d)",
                     name, cursor_col, cursor_row, col, row);
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b1;
        char_valid = 1'b0;
        char_data  = 8'h00;
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({char_ready, wr_en, busy} !== 3'b000 || wr_addr !== 12'd0 || wr_data !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready/wr_en/busy=%b%b%b addr=%0d data=%h required 000/0/00",
                     char_ready, wr_en, busy, wr_addr, wr_data);
        end
        check_cursor("reset_cursor", 0, 0);
        repeat (3) @(negedge clock25);
        reset_n = 1'b1;
        #1;
        vectors++;
        if (char_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: char_ready=%b required 1", char_ready);
        end
    endtask

    task automatic test_printable();
        wlog.delete();
        send(8'h41);
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd0 || wr_data !== 8'h41 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL print_A_write: wr_en=%b addr=%0d data=%h busy=%b required 1/0/41/1",
                     wr_en, wr_addr, wr_data, busy);
        end
        @(negedge clock25);
        check_cursor("print_A_cursor", 1, 0);
        vectors++;
        if (wr_en !== 1'b0 || char_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL print_A_idle: wr_en=%b ready=%b required 0/1", wr_en, char_ready);
        end
    endtask

    // Valid held high: one character every two cycles, data registered.
    task automatic test_back_to_back();
        @(negedge clock25);
        char_valid = 1'b1;
        char_data  = 8'h58;
        @(negedge clock25);
        char_data = 8'h59;
        #1;
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd1 || wr_data !== 8'h58 || char_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: wr_en=%b addr=%0d data=%h ready=%b required 1/1/58/0",
                     wr_en, wr_addr, wr_data, char_ready);
        end
        @(negedge clock25);
        vectors++;
        if (wr_en !== 1'b0 || char_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_gap: wr_en=%b ready=%b required 0/1", wr_en, char_ready);
        end
        @(negedge clock25);
        char_valid = 1'b0;
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd2 || wr_data !== 8'h59) begin
            miscompares++;
            $display("FAIL b2b_second: wr_en=%b addr=%0d data=%h required 1/2/59",
                     wr_en, wr_addr, wr_data);
        end
        @(negedge clock25);
        check_cursor("b2b_cursor", 3, 0);
    endtask

    task automatic test_line_wrap();
        int n;
        int bad;
        send(8'h0D);
        check_cursor("cr_cursor", 0, 0);
        for (int i = 0; i < 79; i++) begin
            send(8'h2E);
            wait_idle(10, n);
        end
        check_cursor("wrap_pre_cursor", 79, 0);
        wlog.delete();
        send(8'h42);
        wait_idle(200, n);
        vectors++;
        if (n != 81) begin
            miscompares++;
            $display("FAIL wrap_busy_cycles: got %0d required 81", n);
        end
        check_cursor("wrap_cursor", 0, 1);
        vectors++;
        if (wlog.size() != 81) begin
            miscompares++;
            $display("FAIL wrap_write_count: got %0d required 81", wlog.size());
        end else begin
            bad = (wlog[0] != {12'd79, 8'h42}) ? 1 : 0;
            for (int i = 1; i < 81; i++)
                if (wlog[i] != {12'(79 + i), 8'h20}) bad++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL wrap_write_seq: %0d wrong entries, first=%0d/%h required 79/42 then 80..159/20",
                         bad, wlog[0].addr, wlog[0].data);
            end
        end
    endtask

    task automatic test_lf();
        int n;
        int bad;
        for (int i = 0; i < 38; i++) begin
            send(8'h0A);
            wait_idle(200, n);
        end
        for (int i = 0; i < 5; i++) begin
            send(8'h61);
            wait_idle(10, n);
        end
        check_cursor("lf_pre_cursor", 5, 39);
        wlog.delete();
        send(8'h0A);
        check_cursor("lf_accept_cursor", 0, 0);
        wait_idle(200, n);
        vectors++;
        bad = 0;
        for (int i = 0; i < wlog.size(); i++)
            if (wlog[i] != {12'(i), 8'h20} || wlog[i].addr == 12'd3125) bad++;
        if (wlog.size() != 80 || bad != 0 || n != 80) begin
            miscompares++;
            $display("FAIL lf_wrap_clear: writes=%0d wrong=%0d busy=%0d required 80/0/80",
                     wlog.size(), bad, n);
        end
    endtask

    task automatic test_backspace();
        int n;
        send(8'h0A); wait_idle(200, n);
        send(8'h0A); wait_idle(200, n);
        for (int i = 0; i < 3; i++) begin
            send(8'h62);
            wait_idle(10, n);
        end
        check_cursor("bs_pre_cursor", 3, 2);
        wlog.delete();
        send(8'h08);
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd162 || wr_data !== 8'h20) begin
            miscompares++;
            $display("FAIL bs_write: wr_en=%b addr=%0d data=%h required 1/162/20",
                     wr_en, wr_addr, wr_data);
        end
        wait_idle(10, n);
        check_cursor("bs_cursor", 2, 2);
        send(8'h08); wait_idle(10, n);
        send(8'h08); wait_idle(10, n);
        wlog.delete();
        send(8'h08);
        vectors++;
        if (wr_en !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL bs_col0_noop: wr_en=%b busy=%b required 0/0", wr_en, busy);
        end
        @(negedge clock25);
        check_cursor("bs_col0_cursor", 0, 2);
        vectors++;
        if (wlog.size() != 0) begin
            miscompares++;
            $display("FAIL bs_col0_writes: got %0d required 0", wlog.size());
        end
    endtask

    task automatic test_other_codes();
        int n;
        wlog.delete();
        send(8'h7E);
        wait_idle(10, n);
        send(8'h7F);
        send(8'h01);
        send(8'h1F);
        @(negedge clock25);
        check_cursor("other_cursor", 1, 2);
        vectors++;
        if (wlog.size() != 1 || wlog[0] != {12'd160, 8'h7E}) begin
            miscompares++;
            $display("FAIL other_writes: count=%0d first=%0d/%h required 1 write 160/7e",
                     wlog.size(), wlog.size() > 0 ? wlog[0].addr : 12'd0,
                     wlog.size() > 0 ? wlog[0].data : 8'd0);
        end
        send(8'h0D);
        vectors++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || cursor_col !== 7'd0) begin
            miscompares++;
            $display("FAIL cr_midline: busy=%b wr_en=%b col=%0d required 0/0/0",
                     busy, wr_en, cursor_col);
        end
    endtask

    task automatic test_clear_screen();
        int n;
        int bad;
        int ready_hi;
        wlog.delete();
        send(8'h0C);
        check_cursor("ff_accept_cursor", 0, 0);
        n = 0;
        ready_hi = 0;
        while (busy === 1'b1 && n < 4000) begin
            if (char_ready !== 1'b0) ready_hi++;
            n++;
            @(negedge clock25);
        end
        vectors++;
        if (n != 3200 || ready_hi != 0) begin
            miscompares++;
            $display("FAIL ff_busy: busy cycles=%0d ready-high cycles=%0d required 3200/0", n, ready_hi);
        end
        bad = 0;
        for (int i = 0; i < wlog.size(); i++)
            if (wlog[i] != {12'(i), 8'h20}) bad++;
        vectors++;
        if (wlog.size() != 3200 || bad != 0) begin
            miscompares++;
            $display("FAIL ff_writes: count=%0d wrong=%0d required 3200/0", wlog.size(), bad);
        end
        check_cursor("ff_end_cursor", 0, 0);
    endtask

    task automatic test_reset_abort();
        int n;
        send(8'h0C);
        repeat (999) @(negedge clock25);
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd999) begin
            miscompares++;
            $display("FAIL abort_position: wr_en=%b addr=%0d required 1/999", wr_en, wr_addr);
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({wr_en, busy, char_ready} !== 3'b000 || wr_addr !== 12'd0 || wr_data !== 8'd0) begin
            miscompares++;
            $display("FAIL abort_outputs: wr_en/busy/ready=%b%b%b addr=%0d data=%h required 000/0/00",
                     wr_en, busy, char_ready, wr_addr, wr_data);
        end
        n = wlog.size();
        repeat (3) @(negedge clock25);
        reset_n = 1'b1;
        #1;
        vectors++;
        if (char_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_release: ready=%b busy=%b required 1/0", char_ready, busy);
        end
        check_cursor("abort_cursor", 0, 0);
        repeat (2) @(negedge clock25);
        vectors++;
        if (wlog.size() != n) begin
            miscompares++;
            $display("FAIL abort_no_writes: %0d extra writes required 0", wlog.size() - n);
        end
        wlog.delete();
        send(8'h51);
        vectors++;
        if (wr_en !== 1'b1 || wr_addr !== 12'd0 || wr_data !== 8'h51) begin
            miscompares++;
            $display("FAIL abort_resume: wr_en=%b addr=%0d data=%h required 1/0/51",
                     wr_en, wr_addr, wr_data);
        end
    endtask

    initial begin
        test_reset();
        test_printable();
        test_back_to_back();
        test_line_wrap();
        test_lf();
        test_backspace();
        test_other_codes();
        test_clear_screen();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 Parameter COLS, default 80, text columns (640 px / 8 px glyph width).
REQ-002 Parameter ROWS, default 40, text rows (480 px / 12 px glyph height).
REQ-003 Parameter FILL_CHAR, default 8'h20, blank code written by clears and backspace.
REQ-004 clock25  input  1  pixel/system clock; the block SHALL use one clock, with all state updated on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 char_valid  input  1  producer has a character code on char_data.
REQ-007 char_data  input  8  character code (ASCII).
REQ-008 char_ready  output  1  block accepts char_data this cycle.
REQ-009 wr_en  output  1  screen-memory write strobe, one cell per cycle.
REQ-010 wr_addr  output  12  cell address = row*COLS + col, range 0..COLS*ROWS-1.
REQ-011 wr_data  output  8  code to store at wr_addr.
REQ-012 cursor_col  output  7  current column, 0..COLS-1.
REQ-013 cursor_row  output  6  current row, 0..ROWS-1.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, WRITE, CLR_LINE and CLR_SCREEN; char_ready SHALL equal (state==IDLE) and reset_n.
REQ-016 A character SHALL be accepted only on a cycle with char_valid and char_ready both high; the code SHALL be registered, and char_data SHALL be ignored at all other times.
REQ-017 Printable code (8'h20..8'h7E) accepted at cycle N: the block SHALL drive wr_en=1, wr_addr=cursor, wr_data=code in cycle N+1 (state WRITE), then advance the cursor.
REQ-018 Advance: col<COLS-1 -> col+1, then IDLE; col=COLS-1 -> col=0, row=row+1 (ROWS-1 wraps to 0), then CLR_LINE.
REQ-019 8'h0A (LF): the block SHALL set col=0 and row=next row (with wrap), then enter CLR_LINE, without writing the current cell.
REQ-020 8'h0D (CR): the block SHALL set col=0, issue no write, and remain in IDLE.
REQ-021 8'h08 (BS): if col>0, the block SHALL set col=col-1 and write FILL_CHAR at the new position in the following cycle (WRITE), then return to IDLE; if col=0, it SHALL perform no operation.
REQ-022 8'h0C (FF): the block SHALL enter CLR_SCREEN, write FILL_CHAR to addresses 0..COLS*ROWS-1 in ascending order (one per cycle, 3200 cycles at the defaults), set the cursor to (0,0), and return to IDLE.
REQ-023 CLR_LINE: the block SHALL write FILL_CHAR to row*COLS+0 .. row*COLS+COLS-1 (COLS consecutive cycles), then return to IDLE; the cursor SHALL stay at (0,row).
REQ-024 All other codes SHALL be consumed with no write and no cursor change.
REQ-025 wr_en SHALL be 0 in IDLE; wr_addr and wr_data are don't-care whenever wr_en=0.
REQ-026 Address arithmetic SHALL be 12-bit unsigned, and wr_addr SHALL never exceed COLS*ROWS-1.
REQ-027 cursor_col and cursor_row SHALL be registered and SHALL update in the same cycle the FSM leaves WRITE, or on acceptance of LF, CR or FF.
REQ-028 Back-to-back printables SHALL sustain one character every 2 cycles.

Reset
REQ-029 Reset assertion SHALL immediately force state=IDLE, wr_en=0, wr_addr=0, wr_data=0, cursor=(0,0) and busy=0, with char_ready=0 while reset_n is low.
REQ-030 Reset asserted mid-clear or mid-write SHALL abort the operation with no further writes; memory contents are left partially updated.
REQ-031 char_ready SHALL rise in the first cycle in which reset_n is high.

Structure
REQ-032 Package vga_text_pkg SHALL hold the COLS/ROWS/CELLS constants, FILL_CHAR, control codes (LF, CR, BS, FF) and the state enum typedef.
REQ-033 Sub-module text_cursor SHALL hold the col/row counters with advance, newline, carriage-return, back and home operations, plus wrap logic.
REQ-034 No memory SHALL be instantiated inside the block; the write port SHALL connect to the screen-memory write side.

Verification
REQ-035 After reset, send 'A'(8'h41) -> one cycle later wr_en=1, wr_addr=0, wr_data=8'h41; cursor=(1,0).
REQ-036 Cursor at (79,0), send 8'h42 -> write addr 79; cursor=(0,1); 80 FILL writes to addr 80..159; busy high for 81 cycles total.
REQ-037 Cursor at (5,39), send LF -> cursor=(0,0); FILL writes to addr 0..79; no write to addr 3125.
REQ-038 Cursor at (3,2), send BS -> cursor=(2,2), write 8'h20 at addr 162; then send BS three times -> third BS produces no write, col stays 0.
REQ-039 Send FF -> 3200 writes of 8'h20 at addr 0..3199 in order; char_ready low throughout; cursor=(0,0) at end.
REQ-040 Assert reset_n low at clear write 1000 of an FF -> wr_en=0 immediately; after release, cursor=(0,0) and char_ready=1.
